// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder.
// It checks a decoded field bundle, packs it into a 32-bit instruction word
// and tags the word with a sequential instruction-memory address. Encoded
// words are queued in a small FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               fmt,
    input  logic [4:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [31:0]              imm,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_illegal,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // FIFO storage: each entry is {instruction, address}
    logic [63:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_addr;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [31:0]       r_out_addr;
    logic              r_err_illegal;
    logic              r_err;

    logic signed [31:0] w_imm_s;
    logic              w_imm_fits_12;
    logic              w_imm_fits_13;
    logic              w_imm_fits_21;
    logic [31:0]       w_instr;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_reject;
    logic              w_pop;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_head_from_push;
    logic [63:0]       w_head_word;

    // Immediate range checks shared by the I/S, B and J formats
    assign w_imm_s       = $signed(imm);
    assign w_imm_fits_12 = (w_imm_s >= -32'sd2048)    && (w_imm_s <= 32'sd2047);
    assign w_imm_fits_13 = (w_imm_s >= -32'sd4096)    && (w_imm_s <= 32'sd4094);
    assign w_imm_fits_21 = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574);

    // Pack the fields for the selected format and decide whether the bundle is legal
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        w_instr = '0;
        w_legal = 1'b0;
        case (fmt)
            FMT_R: begin
                w_instr = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
                w_legal = 1'b1;
            end
            FMT_I: begin
                w_instr = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
                w_legal = w_imm_fits_12;
            end
            FMT_S: begin
                w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
                w_legal = w_imm_fits_12;
            end
            FMT_B: begin
                w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
                w_legal = w_imm_fits_13 && !imm[0];
            end
            FMT_U: begin
                w_instr = {imm[31:12], rd, opcode, 2'b11};
                w_legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
                w_legal = w_imm_fits_21 && !imm[0];
            end
            default: begin
                w_instr = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Handshakes: an illegal bundle is still consumed, it just never reaches the FIFO
    assign in_ready  = (r_count < CNT_W'(DEPTH)) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign w_reject  = w_accept && !w_legal;
    assign w_pop     = r_out_valid && out_ready;

    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // The next head is the word being written only when the FIFO would otherwise be empty
    assign w_head_from_push = w_push && (w_rd_ptr_next == r_wr_ptr);
    assign w_head_word      = w_head_from_push ? {w_instr, r_addr} : r_mem[w_rd_ptr_next];

    // FIFO data write on every legal push
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; the pointers and count decide which entries are meaningful.
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_instr, r_addr};
        end
    end

    // FIFO control, address counter and registered head outputs
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= BASE_ADDR;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_addr      <= BASE_ADDR;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_addr   <= r_addr + 32'd4;
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != '0);
            if (w_count_next != '0) begin
                r_out_instr <= w_head_word[63:32];
                r_out_addr  <= w_head_word[31:0];
            end
        end
    end

    // Rejection pulse and sticky error; a new rejection beats err_clr
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_illegal <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err_illegal <= w_reject;
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_addr    = r_out_addr;
    assign count       = r_count;
    assign err_illegal = r_err_illegal;
    assign err         = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a table of known encodings, hand-written
// sequences for backpressure, errors, flush and reset, and a randomized run
// compared against a queue-based reference model.
module tb_instr_encoder;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        flush;
    logic        err_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [$clog2(DEPTH):0] count;
    logic        err_illegal;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .flush(flush), .err_clr(err_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .count(count), .err_illegal(err_illegal), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        bit          legal;
        logic [31:0] instr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [4:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                         input logic [4:0] rs2_i, input logic [31:0] im);
        fmt = f; opcode = opc; funct3 = f3; funct7 = f7;
        rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = im;
    endtask

    // addi x1, x0, im
    task automatic drive_addi(input logic [31:0] im);
        drive(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, im);
    endtask

    task automatic push_one();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference encoding built from bit positions with shifts and masks
    function automatic logic [31:0] model_encode(input logic [2:0] f, input logic [4:0] opc,
            input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd_i,
            input logic [4:0] rs1_i, input logic [4:0] rs2_i, input logic [31:0] im);
        logic [31:0] w;
        w = (32'(opc) << 2) | 32'h3;
        case (f)
            3'd0: w |= (32'(f7) << 25) | (32'(rs2_i) << 20) | (32'(rs1_i) << 15) | (32'(f3) << 12) | (32'(rd_i) << 7);
            3'd1: w |= ((im & 32'hFFF) << 20) | (32'(rs1_i) << 15) | (32'(f3) << 12) | (32'(rd_i) << 7);
            3'd2: w |= (((im >> 5) & 32'h7F) << 25) | (32'(rs2_i) << 20) | (32'(rs1_i) << 15)
                     | (32'(f3) << 12) | ((im & 32'h1F) << 7);
            3'd3: w |= (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(rs2_i) << 20)
                     | (32'(rs1_i) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            3'd4: w |= (im & 32'hFFFF_F000) | (32'(rd_i) << 7);
            3'd5: w |= (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                     | (((im >> 12) & 32'hFF) << 12) | (32'(rd_i) << 7);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input logic [2:0] f, input logic [31:0] im);
        longint v;
        v = longint'($signed(im));
        case (f)
            3'd0: return 1'b1;
            3'd1, 3'd2: return (v >= -2048) && (v <= 2047);
            3'd3: return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            3'd4: return (im & 32'hFFF) == 32'h0;
            3'd5: return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_addr;
        bit          exp_err;
        logic [31:0] mq_instr [$];
        logic [31:0] mq_addr  [$];
        logic [31:0] m_addr;
        logic [31:0] m_last_instr;
        logic [31:0] m_last_addr;
        bit          m_err;
        int          boundary [15];

        vecs[0]  = '{3'd1, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd5,         1'b1, 32'h0050_0093};
        vecs[1]  = '{3'd3, 5'b11000, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 32'hFE20_8CE3};
        vecs[2]  = '{3'd5, 5'b11011, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h0010_00EF};
        vecs[3]  = '{3'd4, 5'b01101, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7};
        vecs[4]  = '{3'd0, 5'b01100, 3'd0, 7'd0,  5'd3, 5'd1, 5'd2, 32'h0,         1'b1, 32'h0020_81B3};
        vecs[5]  = '{3'd0, 5'b01100, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1, 32'h4020_81B3};
        vecs[6]  = '{3'd2, 5'b01000, 3'd2, 7'd0,  5'd0, 5'd1, 5'd2, 32'd8,         1'b1, 32'h0020_A423};
        vecs[7]  = '{3'd2, 5'b01000, 3'd2, 7'd0,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_AE23};
        vecs[8]  = '{3'd1, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0093};
        vecs[9]  = '{3'd1, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2047,      1'b1, 32'h7FF0_0093};
        vecs[10] = '{3'd3, 5'b11000, 3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'd4094,      1'b1, 32'h7E00_0FE3};
        vecs[11] = '{3'd5, 5'b11011, 3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 1'b1, 32'h8000_006F};
        vecs[12] = '{3'd1, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,      1'b0, 32'h0};
        vecs[13] = '{3'd1, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_F7FF, 1'b0, 32'h0};
        vecs[14] = '{3'd3, 5'b11000, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'd3,         1'b0, 32'h0};
        vecs[15] = '{3'd3, 5'b11000, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'd4096,      1'b0, 32'h0};
        vecs[16] = '{3'd5, 5'b11011, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b0, 32'h0};
        vecs[17] = '{3'd4, 5'b01101, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0, 32'h0};
        vecs[18] = '{3'd6, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd0,         1'b0, 32'h0};
        vecs[19] = '{3'd7, 5'b00100, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd0,         1'b0, 32'h0};

        boundary = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                     -1048576, -1048577, 1048574, 1048575, 1048576, 0};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        drive_addi(32'd0);

        // ---------------- reset state ----------------
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- table of encodings ----------------
        exp_addr = BASE_ADDR;
        exp_err  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].fmt, vecs[i].opc, vecs[i].f3, vecs[i].f7,
                  vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            if (vecs[i].legal) begin
                check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
                check($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
                check($sformatf("vec%0d_addr", i), out_addr, exp_addr);
                check($sformatf("vec%0d_err_illegal", i), 32'(err_illegal), 32'd0);
                exp_addr += 32'd4;
            end else begin
                check($sformatf("vec%0d_err_illegal", i), 32'(err_illegal), 32'd1);
                check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd0);
                exp_err = 1'b1;
            end
            check($sformatf("vec%0d_err", i), 32'(err), 32'(exp_err));
            tick();
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d_pulse_end", i), 32'(err_illegal), 32'd0);
        end

        // ---------------- rejected lui keeps address unadvanced ----------------
        do_reset();
        out_ready = 1'b1;
        drive(3'd4, 5'b01101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        push_one();
        check("lui_instr", out_instr, 32'h1234_52B7);
        check("lui_addr", out_addr, 32'h0);
        tick();
        drive(3'd4, 5'b01101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
        push_one();
        check("lui_bad_pulse", 32'(err_illegal), 32'd1);
        check("lui_bad_err", 32'(err), 32'd1);
        check("lui_bad_no_word", 32'(out_valid), 32'd0);
        drive_addi(32'd5);
        push_one();
        check("after_reject_addr", out_addr, 32'h4);
        check("after_reject_instr", out_instr, 32'h0050_0093);
        tick();

        // ---------------- backpressure and ordering ----------------
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_addi(32'(k));
            in_valid = 1'b1;
            #1;
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd1);
            tick();
        end
        drive_addi(32'd4);
        check("bp_full_count", 32'(count), 32'd4);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("bp_held_count", 32'(count), 32'd4);
        check("bp_head0_addr", out_addr, 32'h0);
        check("bp_head0_instr", out_instr, 32'h0000_0093);
        out_ready = 1'b1;
        tick();
        check("bp_pop_count", 32'(count), 32'd3);
        check("bp_freed_in_ready", 32'(in_ready), 32'd1);
        check("bp_head1_addr", out_addr, 32'h4);
        tick();
        in_valid = 1'b0;
        check("bp_pushpop_count", 32'(count), 32'd3);
        for (int k = 2; k <= 4; k++) begin
            check($sformatf("bp_head%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_head%0d_addr", k), out_addr, 32'(k * 4));
            check($sformatf("bp_head%0d_instr", k), out_instr, 32'h0000_0093 | (32'(k) << 20));
            tick();
        end
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_hold_instr", out_instr, 32'h0040_0093);
        check("bp_hold_addr", out_addr, 32'h10);

        // ---------------- illegal bundles and err_clr ----------------
        do_reset();
        out_ready = 1'b0;
        drive_addi(32'd1);
        push_one();
        check("ill_pre_count", 32'(count), 32'd1);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: drive(3'd3, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
                1: drive_addi(32'd2048);
                default: drive(3'd7, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
            endcase
            push_one();
            check($sformatf("ill%0d_pulse", k), 32'(err_illegal), 32'd1);
            check($sformatf("ill%0d_err", k), 32'(err), 32'd1);
            check($sformatf("ill%0d_count", k), 32'(count), 32'd1);
            tick();
            check($sformatf("ill%0d_pulse_end", k), 32'(err_illegal), 32'd0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_clears", 32'(err), 32'd0);
        err_clr = 1'b1;
        drive(3'd6, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        push_one();
        err_clr = 1'b0;
        check("clr_vs_reject_err", 32'(err), 32'd1);
        check("clr_vs_reject_pulse", 32'(err_illegal), 32'd1);

        // ---------------- flush ----------------
        do_reset();
        out_ready = 1'b0;
        drive_addi(32'd4095);
        push_one();
        for (int k = 0; k < 3; k++) begin
            drive_addi(32'(k + 10));
            push_one();
        end
        check("fl_pre_count", 32'(count), 32'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        drive_addi(32'd99);
        in_valid = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_err_kept", 32'(err), 32'd1);
        drive_addi(32'd7);
        push_one();
        check("fl_next_addr", out_addr, BASE_ADDR);
        check("fl_next_instr", out_instr, 32'h0070_0093);
        tick();

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_addi(32'(k + 20));
            push_one();
        end
        check("mr_pre_count", 32'(count), 32'd2);
        reset = 1'b0;
        drive_addi(32'd5000);
        in_valid = 1'b1;
        tick();
        reset = 1'b1;
        in_valid = 1'b0;
        check("mr_count", 32'(count), 32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_instr", out_instr, 32'h0);
        check("mr_out_addr", out_addr, 32'h0);
        check("mr_err", 32'(err), 32'd0);
        check("mr_err_illegal", 32'(err_illegal), 32'd0);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_addr = BASE_ADDR;
        m_last_instr = 32'h0;
        m_last_addr = 32'h0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit exp_ready;
            bit acc;
            bit leg;
            bit pop;
            bit rej;
            logic [31:0] im;
            logic [2:0]  f;
            case ($urandom % 4)
                0: im = 32'(int'($urandom_range(8191, 0)) - 4096);
                1: im = $urandom;
                2: im = 32'(boundary[$urandom % 15]);
                default: im = $urandom & 32'hFFFF_F000;
            endcase
            f = 3'($urandom % 8);
            drive(f, 5'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im);
            in_valid  = ($urandom % 4) != 0;
            out_ready = (cyc < 1500) ? (($urandom % 10) < 3) : (($urandom % 10) < 8);
            flush     = ($urandom % 40) == 0;
            err_clr   = ($urandom % 16) == 0;
            #1;
            exp_ready = (mq_instr.size() < DEPTH) && !flush;
            check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
            acc = in_valid && exp_ready;
            leg = model_legal(f, im);
            pop = (mq_instr.size() > 0) && out_ready;
            rej = acc && !leg;
            tick();
            if (flush) begin
                mq_instr.delete();
                mq_addr.delete();
                m_addr = BASE_ADDR;
            end else begin
                if (pop) begin
                    void'(mq_instr.pop_front());
                    void'(mq_addr.pop_front());
                end
                if (acc && leg) begin
                    mq_instr.push_back(model_encode(f, opcode, funct3, funct7, rd, rs1, rs2, im));
                    mq_addr.push_back(m_addr);
                    m_addr += 32'd4;
                end
            end
            if (rej) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (mq_instr.size() > 0) begin
                m_last_instr = mq_instr[0];
                m_last_addr  = mq_addr[0];
            end
            check("rnd_out_valid", 32'(out_valid), 32'(mq_instr.size() > 0));
            check("rnd_count", 32'(count), 32'(mq_instr.size()));
            check("rnd_out_instr", out_instr, m_last_instr);
            check("rnd_out_addr", out_addr, m_last_addr);
            check("rnd_err_illegal", 32'(err_illegal), 32'(rej));
            check("rnd_err", 32'(err), 32'(m_err));
        end
        in_valid = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder, the write-side counterpart of the instruction decoder. Takes decoded fields (format, opcode, funct3/funct7, register indices, full-width immediate), validates them, packs them into a standard 32-bit RV32I instruction word, and tags each word with a sequential instruction-memory address. Results are buffered in a small FIFO with valid/ready on both sides. Used by the boot/program loader and self-checking benches to fill instruction memory.

Parameters:
DEPTH, 4, output FIFO depth in words; power of 2, at least 2.
BASE_ADDR, 32'h0000_0000, address assigned to the first word after reset or flush.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
opcode  in  5  instruction[6:2]; bits [1:0] always emitted as 2'b11
funct3  in  3  instruction[14:12], used for R/I/S/B
funct7  in  7  instruction[31:25], used for R only
rd  in  5  destination register, used for R/I/U/J
rs1  in  5  source register A, used for R/I/S/B
rs2  in  5  source register B, used for R/S/B
imm  in  32  signed byte-offset or value immediate
flush  in  1  clear FIFO and reset address counter
err_clr  in  1  clear sticky error
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_instr  out  32  encoded instruction at head
out_addr  out  32  memory address of head word
count  out  $clog2(DEPTH)+1  FIFO occupancy
err_illegal  out  1  one-cycle pulse: last accepted bundle rejected
err  out  1  sticky: at least one rejection since reset/err_clr

Behaviour:
- Reset (reset==0 at an edge): FIFO empty, count=0, out_valid=0, out_instr=0, out_addr=0, err=0, err_illegal=0, address counter=BASE_ADDR. Reset mid-stream discards all queued words.
- in_ready = (count < DEPTH) && !flush. No same-cycle pass-through when full; a pop while full frees a slot the following cycle.
- Push: in_valid && in_ready. Legal bundle is written to the FIFO at that edge with tag = address counter; counter += 4 (wraps modulo 2^32). Word is visible on out_valid/out_instr/out_addr the next cycle (latency 1 on an empty FIFO).
- Pop: out_valid && out_ready advances the head. Simultaneous push and pop: count unchanged, order preserved.
- Encoding (RISC-V standard):
  R = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11}
  I = {imm[11:0], rs1, funct3, rd, opcode, 2'b11}
  S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11}
  B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11}
  U = {imm[31:12], rd, opcode, 2'b11}
  J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11}
- Legality checks, evaluated at push:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]==0.
  - J: imm in [-2^20, 2^20-2] and imm[0]==0.
  - U: imm[11:0]==0.
  - R: no immediate check.
  - fmt 6/7: always illegal.
- Illegal bundle handling: handshake completes (bundle consumed). Nothing is pushed and the address counter does not advance. err_illegal=1 for exactly the next cycle; err set.
- err_clr clears err. If err_clr coincides with a new rejection, the rejection wins and err stays 1.
- flush (highest priority after reset):
  - FIFO emptied and address counter=BASE_ADDR at that edge.
  - in_ready is 0 that cycle, so no push. A same-cycle pop is discarded.
  - err is unaffected.
- All outputs are registered. out_instr/out_addr hold their last value when out_valid=0.

Test Plan:
1. I-type addi x1,x0,5 (fmt=1, opcode=5'b00100, funct3=0, rd=1, rs1=0, imm=5), out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0x0.
2. B-type beq x1,x2,-8 (fmt=3, opcode=5'b11000, rs1=1, rs2=2, imm=-8) -> out_instr=0xFE208CE3; then jal x1,+2048 (fmt=5, opcode=5'b11011, imm=0x800) -> out_instr=0x001000EF at out_addr=0x4.
3. U-type lui x5 (fmt=4, opcode=5'b01101, rd=5, imm=0x12345000) -> out_instr=0x123452B7. Same bundle with imm=0x12345001 -> err_illegal pulse, err=1, no output word, next legal word keeps the unadvanced address.
4. Backpressure, DEPTH=4, out_ready=0, five valid pushes -> in_ready drops after 4th, count=4, 5th held. Raise out_ready -> words drain in order with addrs 0x0,0x4,0x8,0xC,0x10; simultaneous push/pop keeps count steady.
5. Illegal cases: B imm=3, I imm=2048, fmt=7 -> each yields one err_illegal pulse, err=1, count unchanged. err_clr -> err=0. err_clr together with a new rejection -> err stays 1.
6. Flush with 3 queued words and in_valid=1 -> next cycle count=0, out_valid=0, push discarded. Next legal push gets BASE_ADDR. Repeat using reset=0 mid-stream -> all outputs at reset values.
